// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/timing constants.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_CLK_DIV    = 4;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Clear-able CLK_DIV divider; tick is a registered one-cycle pulse on terminal count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with
// mid-bit sampling, false-start rejection, framing/overrun detection and valid/ack output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int CLK_DIV    = UART_CLK_DIV,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] data_output,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output rx_state_t            rx_state
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_meta;
  logic                 rxs;
  logic                 tick;
  logic                 tick_clear;
  rx_state_t            state;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
  logic                 parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_state   = state;
  assign tick_clear = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rxs     <= rx_meta;
    end
  end

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Handshake: a byte is held while rx_valid=1; rx_ack sampled with rx_valid=1 consumes it
  // (and clears overrun) on that edge. A frame completing on the same edge as the ack
  // replaces the consumed byte, so rx_valid stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_output <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            state      <= START;
          end
        end

        START: begin
          if (tick) begin
            if (sample_cnt == SW'(OVERSAMPLE / 2 - 1)) begin
              sample_cnt <= '0;
              state      <= rxs ? IDLE : DATA;
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
              sample_cnt <= '0;
              shreg      <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
              sample_cnt <= '0;
              parity_bad <= rxs ^ (^shreg);
              state      <= STOP;
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
              sample_cnt <= '0;
              if (rxs) begin
                if (!rx_valid || rx_ack) begin
                  data_output <= shreg;
                  rx_valid    <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_err_q <= parity_bad;
`endif
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level timing model plus directed literal checks.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int T = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Falling edge of the start bit to stop-bit sample: 2 sync + 1 idle exit + 9.5 bits + 1 register
  localparam int LAT = 612 + (PAR_EN ? T : 0);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] data_output;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  rx_state_t  rx_state;

  always #5 clk = ~clk;

  uart_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .Rx          (Rx),
    .data_output (data_output),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .rx_state    (rx_state)
  );

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         ok;
    bit         perr;
  } ev_t;

  ev_t        exp_q[$];
  int         ack_q[$];
  int         edge_n = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_pe = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Model: a frame completes LAT edges after its start edge; output rules applied per edge.
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (!reset) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_data = 8'h00;
      exp_q.delete();
    end else begin
      m_fe = 1'b0;
      m_pe = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].at == edge_n) begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.ok) begin
          if (!m_valid || rx_ack) begin
            m_data  = e.data;
            m_valid = 1'b1;
            if (rx_ack) m_ovr = 1'b0;
          end else begin
            m_ovr = 1'b1;
          end
          m_pe = e.perr;
        end else begin
          m_fe = 1'b1;
          if (rx_ack && m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
        end
      end else if (rx_ack && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  end

  // Ack driver: each queued edge number gets rx_ack high for exactly that sampling edge.
  initial forever begin
    @(posedge clk);
    #2;
    while (ack_q.size() > 0 && ack_q[0] <= edge_n) void'(ack_q.pop_front());
    if (ack_q.size() > 0 && ack_q[0] == edge_n + 1) begin
      rx_ack = 1'b1;
      void'(ack_q.pop_front());
    end else begin
      rx_ack = 1'b0;
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (reset) begin
      check("rx_valid", rx_valid, m_valid);
      check("data_output", data_output, m_data);
      check("overrun", overrun, m_ovr);
      check("frame_err", frame_err, m_fe);
      check("parity_err", parity_err, m_pe);
    end
  end

  task automatic wait_edge(input int t);
    while (edge_n < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_bit(input logic b);
    Rx = b;
    repeat (T) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
    ev_t e;
    @(posedge clk);
    #1;
    e.at = edge_n + LAT; e.data = d; e.ok = stop_b; e.perr = bad_par & PAR_EN;
    exp_q.push_back(e);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    if (PAR_EN) hold_bit((^d) ^ bad_par);
    hold_bit(stop_b);
  endtask

  task automatic ack_now();
    int t;
    t = edge_n;
    ack_q.push_back(t + 1);
    wait_edge(t + 2);
  endtask

  int f;
  int g;

  initial begin
    #1;
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", data_output, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_state", rx_state, IDLE);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Single frame: exact latency, then ack clears next cycle
    f = edge_n + 1;
    ack_q.push_back(f + LAT + 1);
    fork
      send_frame(8'hF5, 1'b1, 1'b0);
      begin
        wait_edge(f + LAT - 1);
        check("f5_not_yet", rx_valid, 1'b0);
        wait_edge(f + LAT);
        check("f5_valid", rx_valid, 1'b1);
        check("f5_data", data_output, 8'hF5);
        wait_edge(f + LAT + 1);
        check("f5_acked", rx_valid, 1'b0);
      end
    join
    repeat (20) @(posedge clk);
    #1;

    // False start
    g = edge_n + 1;
    @(posedge clk); #1;
    Rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    Rx = 1'b1;
    wait_edge(g + 30);
    check("glitch_start", rx_state, START);
    wait_edge(g + 40);
    check("glitch_idle", rx_state, IDLE);
    check("glitch_novalid", rx_valid, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("f3c_data", data_output, 8'h3C);
    check("f3c_valid", rx_valid, 1'b1);
    ack_now();

    // Bad stop bit, line then held low
    f = edge_n + 1;
    fork
      send_frame(8'hA5, 1'b0, 1'b0);
      begin
        wait_edge(f + LAT);
        check("a5_frame_err", frame_err, 1'b1);
        wait_edge(f + LAT + 1);
        check("a5_fe_pulse", frame_err, 1'b0);
        check("a5_wait_high", rx_state, WAIT_HIGH);
      end
    join
    repeat (300) @(posedge clk);
    #1;
    check("low_wait_high", rx_state, WAIT_HIGH);
    check("low_novalid", rx_valid, 1'b0);
    Rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1, 1'b0);
    check("f5a_data", data_output, 8'h5A);
    ack_now();

    // Overrun, then ack coincident with completion
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_data", data_output, 8'h11);
    check("ovr_flag", overrun, 1'b1);
    ack_now();
    check("ovr_cleared", overrun, 1'b0);
    check("ovr_valid_cleared", rx_valid, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    ack_q.push_back(edge_n + 1 + LAT);
    send_frame(8'h22, 1'b1, 1'b0);
    check("coinc_data", data_output, 8'h22);
    check("coinc_valid", rx_valid, 1'b1);
    check("coinc_overrun", overrun, 1'b0);
    ack_now();

`ifdef UART_RX_PARITY_EN
    f = edge_n + 1;
    fork
      send_frame(8'h07, 1'b1, 1'b1);
      begin
        wait_edge(f + LAT);
        check("par_err", parity_err, 1'b1);
        check("par_valid", rx_valid, 1'b1);
        check("par_data", data_output, 8'h07);
        wait_edge(f + LAT + 1);
        check("par_pulse", parity_err, 1'b0);
      end
    join
    ack_now();
`endif

    // Reset mid-frame while a byte is still pending
    send_frame(8'h42, 1'b1, 1'b0);
    f = edge_n + 1;
    fork
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        wait_edge(f + 5 * T + 30);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_data", data_output, 8'h00);
        check("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_state", rx_state, IDLE);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
      end
    join
    send_frame(8'h81, 1'b1, 1'b0);
    check("post_rst_data", data_output, 8'h81);
    check("post_rst_valid", rx_valid, 1'b1);
    ack_now();
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Standalone UART receive path: recovers 8N1 frames (optionally 8E1) from the serial line driven by the existing `uart` transmitter's `Tx` output and presents each byte through a valid/ack handshake. It uses oversampling with mid-bit sampling, false-start rejection, and framing and overrun detection. It sits between the serial pin and the byte-consuming logic and replaces ad-hoc loopback of a second `uart` instance.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `CLK_DIV`, 4: `clk` cycles per oversample tick; must be ≥ 1.
- `OVERSAMPLE`, 16: ticks per bit period; must be even and ≥ 4.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Rx`  in  1  serial line; idles high; asynchronous to `clk`.
- `data_output`  out  DATA_BITS  last accepted byte; reset 0.
- `rx_valid`  out  1  byte available; reset 0.
- `rx_ack`  in  1  consumer accepts the byte.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit; reset 0.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch; reset 0.
- `overrun`  out  1  sticky; a frame was lost because `rx_valid` was still high; reset 0.

## Operation
Input path:
- `Rx` passes through a 2-flop synchronizer; both flops reset to 1.
- All decoding uses the synchronized `rxs` signal.

Tick generator:
- Counts 0..CLK_DIV-1 and pulses `tick` on the terminal count.
- Held at 0 in IDLE, so sampling phase is locked to the detected start edge.

State machine: IDLE → START → DATA → [PARITY] → STOP → (IDLE | WAIT_HIGH).
- IDLE: when `rxs`=0, clear the tick and sample counters, go to START.
- START: after OVERSAMPLE/2 ticks, sample `rxs`. If 1, it is a glitch: go to IDLE with no output. If 0, clear the sample counter and go to DATA.
- DATA: every OVERSAMPLE ticks, shift `rxs` into the MSB of the shift register (LSB arrives first). After DATA_BITS samples, go to PARITY if enabled, else STOP.
- PARITY: after OVERSAMPLE ticks, sample and compare to even parity of the data. Record the mismatch and go to STOP.
- STOP, after OVERSAMPLE ticks, sample `rxs`:
  - If 1: the frame is good; run the delivery rules below and go to IDLE.
  - If 0: pulse `frame_err`, discard the byte (no `rx_valid`), go to WAIT_HIGH.
- WAIT_HIGH (break or line held low): stay until `rxs`=1, then go to IDLE.

Delivery of a good frame:
- `rx_valid`=0: load `data_output`, set `rx_valid`.
- `rx_valid`=1 and `rx_ack`=0: set `overrun`; `data_output` keeps the old byte; the new byte is dropped.
- `rx_valid`=1 and `rx_ack`=1 in the same cycle: load the new byte, `rx_valid` stays 1, no overrun.
- `parity_err` pulses in the same cycle as delivery; the byte is still delivered.

Handshake:
- `rx_ack` with `rx_valid`=1 clears `rx_valid` and `overrun` on the next edge.
- `rx_ack` with `rx_valid`=0 is ignored.

Reset:
- `reset`=0 at any time, including mid-frame, forces IDLE and clears all counters and outputs immediately.
- A frame in progress is lost. After release, the receiver waits for a fresh falling edge.

## Timing
- Bit period: T = CLK_DIV·OVERSAMPLE cycles (64 at defaults).
- Latency from the `Rx` falling edge to `rx_valid` high, 8N1: 2 (sync) + 1 (IDLE exit) + 9.5·T + 1 (register) = 612 cycles at defaults.
- With parity enabled, add T.
- Samples land at mid-bit ±1 `clk`.
- Tolerates ±(OVERSAMPLE/2−1)/(10·OVERSAMPLE) baud mismatch.
- `rx_valid` stays high indefinitely until acked.
- `frame_err` and `parity_err` are exactly one cycle wide.
- Back-to-back frames: a start edge immediately after a good stop sample is detected, because the STOP → IDLE exit happens at mid-stop-bit.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, the frame carries an even-parity bit, and `parity_err` is driven as above.
- Not defined: PARITY is omitted, the frame is 8N1, and `parity_err` is tied to 0. The port list is identical either way.

## Structure
- Shared package `uart_pkg`:
  - receiver state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - default constants `UART_DATA_BITS`, `UART_CLK_DIV`, `UART_OVERSAMPLE`.
- Sub-module `uart_baud_tick`: the clear-able CLK_DIV counter producing `tick`, reusable by a future transmitter.

## Test plan
- 8N1, defaults, send 0xF5, then idle → `data_output`=0xF5, `rx_valid` rises 612 cycles after the start edge, no error pulses; `rx_ack` clears it next cycle.
- 20-cycle low glitch on `Rx` → no `rx_valid`, state back to IDLE; a following 0x3C frame is received correctly.
- Frame 0xA5 with stop bit forced 0, then line held low 300 cycles → one `frame_err` pulse, no `rx_valid`; the next 0x5A frame is received only after the line returns high.
- Two frames 0x11 then 0x22, never acked → `data_output`=0x11, `overrun`=1; after `rx_ack`, both clear. A repeat with `rx_ack` coincident with the second completion → 0x22, `rx_valid`=1, `overrun`=0.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 (wrong) → `parity_err` pulse coincident with `rx_valid`, `data_output`=0x07.
- `reset` low at bit 4 of 0xFF, released, then 0x81 sent → all outputs 0 during reset, first `rx_valid` carries 0x81.
